// File: rtl/pe_pkg.sv
// Shared constants and types for the PE convolution sequencer.
// The window and filter sizes are fixed by the packet format.
package pe_pkg;
  localparam int DWIDTH = 8;
  localparam int NPIX   = 5;
  localparam int NTAP   = 3;
  localparam int ACC_W  = 2*DWIDTH + 2;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUT} pe_seq_state_t;
  typedef logic [1:0] psum_idx_t;
endpackage

// File: rtl/pe_mac.sv
// Registered unsigned multiply-accumulate shared by all taps.
// When clear is set, this product starts a new sum.
module pe_mac
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [2*DWIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clear ? '0 : acc) + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/pe_conv_seq.sv
// Sequencer for one PE's 3-tap, 5-pixel 1-D convolution.
// It captures a filter row and a pixel window, then emits 3 psums through one shared MAC.
module pe_conv_seq
  import pe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   filt_valid,
  input  logic [NTAP*DWIDTH-1:0] filt_data,
  output logic                   filt_ready,
  input  logic                   pix_valid,
  input  logic [NPIX*DWIDTH-1:0] pix_data,
  output logic                   pix_ready,
  output logic                   psum_valid,
  input  logic                   psum_ready,
  output logic [ACC_W-1:0]       psum_data,
  output psum_idx_t              psum_idx,
  output logic                   window_done,
  output logic                   busy
);
  pe_seq_state_t     state;
  logic              filt_loaded;
  logic              pix_loaded;
  psum_idx_t         k;
  logic [1:0]        t;
  logic [DWIDTH-1:0] filt_reg  [NTAP];
  logic [DWIDTH-1:0] pix_reg   [NPIX];
  logic [DWIDTH-1:0] filt_word [NTAP];
  logic [DWIDTH-1:0] pix_word  [NPIX];
  logic              filt_hs;
  logic              pix_hs;
  logic [2:0]        pix_sel;
  logic [ACC_W-1:0]  acc;

  genvar gi;
  generate
    for (gi = 0; gi < NTAP; gi++) begin : g_filt_word
      assign filt_word[gi] = filt_data[DWIDTH*gi +: DWIDTH];
    end
    for (gi = 0; gi < NPIX; gi++) begin : g_pix_word
      assign pix_word[gi] = pix_data[DWIDTH*gi +: DWIDTH];
    end
  endgenerate

  // Readies are gated by rst_n so they read low for the whole reset assertion.
  assign filt_ready = rst_n && (state == IDLE);
  assign pix_ready  = rst_n && (state == IDLE) && !pix_loaded;
  assign filt_hs    = filt_valid && filt_ready;
  assign pix_hs     = pix_valid && pix_ready;

  assign psum_valid = (state == OUT);
  assign busy       = (state != IDLE);
  assign psum_idx   = k;
  assign pix_sel    = 3'(k) + 3'(t);

  // The accumulator is frozen outside COMPUTE, so it doubles as the held psum.
  assign psum_data  = acc;

  pe_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (t == 2'd0),
    .en    (state == COMPUTE),
    .a     (pix_reg[pix_sel]),
    .b     (filt_reg[t]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      filt_loaded <= 1'b0;
      pix_loaded  <= 1'b0;
      k           <= '0;
      t           <= '0;
      window_done <= 1'b0;
      for (int j = 0; j < NTAP; j++) filt_reg[j] <= '0;
      for (int i = 0; i < NPIX; i++) pix_reg[i] <= '0;
    end else begin
      window_done <= 1'b0;
      case (state)
        IDLE: begin
          if (filt_hs) begin
            for (int j = 0; j < NTAP; j++) filt_reg[j] <= filt_word[j];
            filt_loaded <= 1'b1;
          end
          if (pix_hs) begin
            for (int i = 0; i < NPIX; i++) pix_reg[i] <= pix_word[i];
            pix_loaded <= 1'b1;
          end
          if ((filt_loaded || filt_hs) && (pix_loaded || pix_hs)) begin
            state <= COMPUTE;
            k     <= '0;
            t     <= '0;
          end
        end
        COMPUTE: begin
          if (t == 2'd2) begin
            t     <= '0;
            state <= OUT;
          end else begin
            t <= t + 2'd1;
          end
        end
        OUT: begin
          if (psum_ready) begin
            if (k == 2'd2) begin
              window_done <= 1'b1;
              pix_loaded  <= 1'b0;
              k           <= '0;
              state       <= IDLE;
            end else begin
              k     <= k + 2'd1;
              t     <= '0;
              state <= COMPUTE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
